// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, SubBytes FSM encoding and the forward
// and inverse S-box tables used by every S-box lane.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = AES_BLOCK_W / 8;
    localparam int BYTE_IDX_W  = $clog2(AES_BYTES);

    // Raw state codes; the enum below is bound to them so the encoding is fixed
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } sb_state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: looks a byte up in the forward or inverse
// table depending on the mode bit.
module aes_sbox_lane (
    input  logic [7:0] i_byte,
    input  logic       i_inverse,
    output logic [7:0] o_byte
);
    import aes_pkg::*;

    // Table lookup, mode picks forward or inverse substitution
    always_comb begin
        o_byte = i_inverse ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Handshaked SubBytes engine. NUM_LANES S-box lanes are reused over
// 16/NUM_LANES beats to substitute a whole 128-bit state; the result is held
// until downstream takes it, and a new block may be accepted on that same edge.
module sub_bytes_seq #(
    parameter int NUM_LANES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data_in,
    input  logic         i_inverse,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data_out,
    output logic         o_busy
);
    import aes_pkg::*;

    localparam int BEATS = AES_BYTES / NUM_LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Only lane counts that divide the 16-byte state evenly are supported
    if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4 ||
          NUM_LANES == 8 || NUM_LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: NUM_LANES must be one of 1, 2, 4, 8, 16");
    end

    sb_state_t                          state_p0;
    logic [CNT_W-1:0]                   cnt_p0;
    logic                               inv_p0;
    logic [AES_BYTES-1:0][7:0]          src_p0;
    logic [AES_BYTES-1:0][7:0]          res_p1;
    logic [NUM_LANES-1:0][7:0]          lane_in;
    logic [NUM_LANES-1:0][7:0]          lane_out;
    logic [BYTE_IDX_W-1:0]              base_idx;
    logic                               accept;
    logic                               last_beat;

    // Handshake and status decode
    assign o_valid   = (state_p0 == DONE);
    assign o_busy    = (state_p0 == BUSY);
    assign o_ready   = (state_p0 == IDLE) || ((state_p0 == DONE) && i_ready);
    assign accept    = i_valid && o_ready;
    assign last_beat = (cnt_p0 == LAST_BEAT);

    // First byte handled in the current beat; lane j takes byte base_idx+j
    assign base_idx  = BYTE_IDX_W'(int'(cnt_p0) * NUM_LANES);

    assign o_data_out = res_p1;

    // Route the current beat's source bytes onto the lanes
    always_comb begin
        lane_in = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            lane_in[j] = src_p0[base_idx + BYTE_IDX_W'(j)];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox_lane u_lane (
            .i_byte    (lane_in[g]),
            .i_inverse (inv_p0),
            .o_byte    (lane_out[g])
        );
    end

    // Control FSM: accept -> BUSY for BEATS cycles -> DONE until taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (accept) begin
                        state_p0 <= BUSY;
                        cnt_p0   <= '0;
                    end
                end
                BUSY: begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                    if (last_beat) begin
                        state_p0 <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_p0 <= accept ? BUSY : IDLE;
                        cnt_p0   <= '0;
                    end
                end
                default: begin
                    state_p0 <= IDLE;
                    cnt_p0   <= '0;
                end
            endcase
        end
    end

    // Datapath: capture block and mode on accept, fill result bytes per beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            src_p0 <= '0;
            res_p1 <= '0;
            inv_p0 <= 1'b0;
        end else begin
            if (accept) begin
                src_p0 <= i_data_in;
                inv_p0 <= i_inverse;
            end
            if (state_p0 == BUSY) begin
                for (int j = 0; j < NUM_LANES; j++) begin
                    res_p1[base_idx + BYTE_IDX_W'(j)] <= lane_out[j];
                end
            end
        end
    end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Parametrised, handshaked SubBytes engine for the AES datapath. It applies the forward or inverse AES S-box to a 128-bit state using `NUM_LANES` S-box lanes time-multiplexed over `16/NUM_LANES` beats. This lets round logic trade area against latency, and one instance serves both encryption and decryption. It sits between AddRoundKey and ShiftRows, and uses valid/ready on both sides so it can be stalled by downstream stages.

## Interface
- `NUM_LANES`, default 4: S-box lanes instantiated. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `BEATS`, localparam `16/NUM_LANES`: cycles per block.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk` input, 1: clock, rising edge.
- `i_rst_n` input, 1: asynchronous active-low reset.
- `i_valid` input, 1: input block present.
- `o_ready` output, 1: engine can accept a block.
- `i_data_in` input, 128: state; byte i = bits [8i+7:8i].
- `i_inverse` input, 1: 0 = forward S-box, 1 = inverse S-box; sampled with the block.
- `o_valid` output, 1: result present.
- `i_ready` input, 1: downstream accepts the result.
- `o_data_out` output, 128: substituted state, same byte order.
- `o_busy` output, 1: high while beats are in progress.

## Operation
- FSM states:
  - IDLE: `o_ready`=1.
  - BUSY: beats in progress; `o_ready`=0, `o_valid`=0.
  - DONE: result held; `o_valid`=1.
- Accept: occurs when `i_valid` && `o_ready` at a rising edge. On accept:
  - Latch `i_data_in` into the source register and `i_inverse` into the mode flag.
  - Clear the beat counter and go to BUSY.
- Beat k, for k = 0..BEATS-1:
  - Lane j processes byte k·NUM_LANES+j of the source register.
  - Each lane selects the forward or inverse table by the latched mode.
  - The result is written into the matching byte of the result register.
  - The counter increments; on k = BEATS-1 go to DONE.
- S-box lanes are combinational. Only the source register, result register, counter, mode flag and state are flops.
- DONE:
  - `o_data_out` and `o_valid` are held stable until `i_valid`... specifically until `i_ready`=1; the handshake completes on `o_valid` && `i_ready`.
  - `o_ready` = `i_ready` in DONE, so back-to-back blocks need no idle cycle.
  - Output taken with no new `i_valid`: go to IDLE.
  - Output taken and `i_valid`=1 in the same cycle: accept the new block and go straight to BUSY.
- Inputs arriving during BUSY are ignored, because `o_ready`=0. The upstream stage must hold `i_valid` and its data.
- `o_data_out` keeps the last result after the handshake. It is not cleared.

## Timing
- Reset (async assert, sync release) gives:
  - State IDLE.
  - `o_valid`=0, `o_busy`=0, `o_ready`=1, `o_data_out`=0.
  - Source, result, counter and mode all cleared.
- Reset asserted mid-block abandons the block immediately. No output is produced.
- Latency: `o_valid` rises BEATS cycles after the accept edge.
  - `NUM_LANES`=16: 1 cycle.
  - `NUM_LANES`=4: 4 cycles.
  - `NUM_LANES`=1: 16 cycles.
- Throughput: one block per BEATS cycles when downstream is always ready.
- `o_busy` is high exactly the BEATS cycles following accept.
- Counter width is $clog2(BEATS), minimum 1 bit. Wrap is never used; the counter is reset on accept.

## Structure
- Shared package `aes_pkg` holds:
  - `SBOX_FWD[256]` and `SBOX_INV[256]` byte constant arrays.
  - The FSM enum `sb_state_t` {IDLE, BUSY, DONE}.
  - The `AES_BLOCK_W`=128 constant.
- Sub-module `aes_sbox_lane`: combinational lane with `i_byte`[7:0], `i_inverse` and `o_byte`[7:0], indexing the package tables. It is instantiated `NUM_LANES` times in a generate loop.

## Test plan
- FIPS-197 block, `NUM_LANES`=4, forward mode: input 193de3bea0f4e22b9ac68d2ae9f84808 gives d42711aee0bf98f1b8b45de51e415230. `o_valid` rises 4 cycles after accept.
- Inverse mode, same block: input d42711aee0bf98f1b8b45de51e415230 gives 193de3bea0f4e22b9ac68d2ae9f84808. Single-byte checks:
  - Forward: 0x00→0x63, 0x53→0xED, 0xFF→0x16.
  - Inverse: 0x63→0x00.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE. `o_data_out` and `o_valid` stay stable and `o_ready`=0. On release, the handshake occurs in one cycle.
- Back-to-back: `i_valid` held high with a new block while DONE and `i_ready`=1. The new block is accepted on the same edge, with no IDLE cycle, and both results are correct.
- Reset mid-block: drop `i_rst_n` at beat 2. Outputs immediately return to `o_valid`=0, `o_busy`=0, `o_ready`=1 and `o_data_out`=0.
- Parameter sweep over `NUM_LANES` ∈ {1, 2, 8, 16}, using all-0x00 input:
  - Result is all 0x63.
  - Latency is 16, 8, 2 and 1 cycles respectively.
